// File: rtl/multiplier_iterative_param.sv
// Iterative shift-and-add multiplier with configurable operand width and
// multiplier bits retired per cycle. It computes the full 2*WIDTH product of
// two operands, each treated as signed or unsigned on request, which covers
// MUL/MULH/MULHSU/MULHU. Leading zeros of the multiplier are skipped, so
// small multipliers finish early.
//
// Ports:
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_valid / o_ready   request handshake; o_ready is high only when idle
//   i_a, i_b            multiplicand / multiplier, sampled only on accept
//   i_op_a_signed_en    treat i_a as two's complement
//   i_op_b_signed_en    treat i_b as two's complement
//   i_flush             abort the current operation; o_product is kept
//   o_valid / i_result_ready  result handshake; the result is held under back-pressure
//   o_product           full 2*WIDTH product
module multiplier_iterative_param #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_op_a_signed_en,
  input  logic                 i_op_b_signed_en,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_result_ready,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [ProdW-1:0]    acc_q, acc_d;
  logic [ProdW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic                sign_q, sign_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ProdW-1:0]    product_q, product_d;

  logic                sign_a, sign_b;
  logic [WIDTH-1:0]    abs_a, abs_b;
  logic [ProdW-1:0]    partial;
  logic [ProdW-1:0]    sum;

  // Number of CALC cycles needed to consume every bit of b up to and including
  // its highest set bit, BITS_PER_CYCLE bits at a time.
  function automatic logic [CntW-1:0] calc_steps(input logic [WIDTH-1:0] b);
    int unsigned len;
    len = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (b[i]) len = i + 1;
    end
    return CntW'((len + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE);
  endfunction

  // Operand magnitudes; -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is exact
  // when read as unsigned.
  always_comb begin
    sign_a = i_op_a_signed_en & i_a[WIDTH-1];
    sign_b = i_op_b_signed_en & i_b[WIDTH-1];
    abs_a  = sign_a ? -i_a : i_a;
    abs_b  = sign_b ? -i_b : i_b;
  end

  // Multiple of |a| selected by the low BITS_PER_CYCLE bits of the remaining
  // multiplier. The multiplicand is pre-shifted each cycle, so no final
  // alignment is needed when leading zeros are skipped.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
    sum = acc_q + partial;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          acc_d    = '0;
          mcand_d  = ProdW'(abs_a);
          mplier_d = abs_b;
          sign_d   = sign_a ^ sign_b;
          cnt_d    = calc_steps(abs_b);
          if (abs_a == '0 || abs_b == '0) begin
            state_d   = StDone;
            product_d = '0;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d    = sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d   = StDone;
          product_d = sign_q ? -sum : sum;
        end
      end
      StDone: begin
        if (i_result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over accept, completion and the result handshake; the
    // in-flight result is dropped and the last delivered product is kept.
    if (i_flush) begin
      state_d   = StIdle;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      sign_d    = sign_q;
      cnt_d     = '0;
      product_d = product_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign o_ready   = (state_q == StIdle);
  assign o_valid   = (state_q == StDone);
  assign o_product = product_q;

endmodule

// File: tb/tb_multiplier_iterative_param.sv
// Bench for multiplier_iterative_param: three instances (32/1, 16/2, 16/4)
// share operands, reset, flush and result-ready; each has its own i_valid.
module tb_multiplier_iterative_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, rr, asg, bsg;
  logic [31:0] op_a, op_b;
  logic        valid0, valid1, valid2;
  logic        ready0, ready1, ready2;
  logic        ovalid0, ovalid1, ovalid2;
  logic [63:0] p0;
  logic [31:0] p1, p2;

  multiplier_iterative_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid0), .o_ready(ready0),
    .i_a(op_a), .i_b(op_b), .i_op_a_signed_en(asg), .i_op_b_signed_en(bsg),
    .i_flush(flush), .o_valid(ovalid0), .i_result_ready(rr), .o_product(p0)
  );

  multiplier_iterative_param #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(ready1),
    .i_a(op_a[15:0]), .i_b(op_b[15:0]), .i_op_a_signed_en(asg), .i_op_b_signed_en(bsg),
    .i_flush(flush), .o_valid(ovalid1), .i_result_ready(rr), .o_product(p1)
  );

  multiplier_iterative_param #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid2), .o_ready(ready2),
    .i_a(op_a[15:0]), .i_b(op_b[15:0]), .i_op_a_signed_en(asg), .i_op_b_signed_en(bsg),
    .i_flush(flush), .o_valid(ovalid2), .i_result_ready(rr), .o_product(p2)
  );

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] p;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic get_valid(input int sel);
    return (sel == 0) ? ovalid0 : (sel == 1) ? ovalid1 : ovalid2;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ready0 : (sel == 1) ? ready1 : ready2;
  endfunction

  function automatic logic [63:0] get_prod(input int sel);
    return (sel == 0) ? p0 : (sel == 1) ? {32'd0, p1} : {32'd0, p2};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one request; the accept edge is the posedge inside. Returns #1
  // after that edge (cycle 1) with operands scrambled.
  task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [63:0] exp,
                          input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    chk("ready_before_accept", {63'd0, get_ready(sel)}, 64'd1);
    op_a   = a;
    op_b   = b;
    asg    = sa;
    bsg    = sb;
    valid0 = (sel == 0);
    valid1 = (sel == 1);
    valid2 = (sel == 2);
    if (push) begin
      e.p   = exp;
      e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    asg    = 1'($urandom);
    bsg    = 1'($urandom);
  endtask

  task automatic wait_result(input int sel);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!get_valid(sel) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = sb_q.pop_front();
    chk("valid_seen", {63'd0, get_valid(sel)}, 64'd1);
    chk("latency", 64'(cyc + 1), 64'(e.lat));
    chk("product", get_prod(sel), e.p);
  endtask

  task automatic handshake(input int sel);
    rr = 1'b1;
    @(posedge clk);
    #1;
    rr = 1'b0;
    chk("valid_after_hs", {63'd0, get_valid(sel)}, 64'd0);
    chk("ready_after_hs", {63'd0, get_ready(sel)}, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    start_op(v.sel, v.a, v.b, v.sa, v.sb, v.exp, v.lat, 1'b1);
    wait_result(v.sel);
    handshake(v.sel);
  endtask

  initial begin
    logic [63:0] held;
    bit          seen;

    rst = 1'b1; flush = 1'b0; rr = 1'b0; asg = 1'b0; bsg = 1'b0;
    op_a = '0; op_b = '0; valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;

    // sel, a, b, sa, sb, expected product, o_valid cycle
    vecs.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, 33});
    vecs.push_back('{0, 32'hFFFFFFFF, 32'h00000007, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF9, 4});
    vecs.push_back('{0, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 64'hC000000000000000, 33});
    vecs.push_back('{0, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, 33});
    vecs.push_back('{0, 32'h00000000, 32'h00000005, 1'b0, 1'b0, 64'h0, 1});
    vecs.push_back('{0, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 64'h0, 1});
    vecs.push_back('{0, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'd15, 4});
    vecs.push_back('{0, 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1, 1'b1, 64'd15, 4});
    vecs.push_back('{0, 32'h00000005, 32'hFFFFFFFB, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFE7, 4});
    vecs.push_back('{0, 32'h12345678, 32'h00000100, 1'b0, 1'b0, 64'h0000001234567800, 10});
    vecs.push_back('{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001, 33});
    vecs.push_back('{1, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'd15, 3});
    vecs.push_back('{1, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 64'h00000000FFFE0001, 9});
    vecs.push_back('{1, 32'h00008000, 32'h00008000, 1'b1, 1'b1, 64'h0000000040000000, 9});
    vecs.push_back('{2, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'd15, 2});
    vecs.push_back('{2, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 64'h00000000FFFE0001, 5});
    vecs.push_back('{2, 32'h0000FFFF, 32'h00000007, 1'b1, 1'b1, 64'h00000000FFFFFFF9, 2});

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", {63'd0, ready0}, 64'd1);
    chk("reset_valid", {63'd0, ovalid0}, 64'd0);
    chk("reset_product", p0, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: result held for 10 cycles, requests in DONE ignored.
    start_op(0, 32'h1234, 32'h10, 1'b0, 1'b0, 64'h12340, 6, 1'b1);
    wait_result(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid0 = 1'b1;
      op_a   = $urandom;
      op_b   = 32'h3;
      @(posedge clk);
      #1;
      chk("bp_ready", {63'd0, ready0}, 64'd0);
      chk("bp_valid", {63'd0, ovalid0}, 64'd1);
      chk("bp_product", p0, 64'h12340);
    end
    valid0 = 1'b0;
    handshake(0);
    chk("bp_product_after_hs", p0, 64'h12340);
    run_vec('{0, 32'd7, 32'd9, 1'b0, 1'b0, 64'd63, 5});

    // Flush at cycle 5 of a 32-cycle calculation.
    start_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'd0, 0, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", {63'd0, ready0}, 64'd1);
    chk("flush_valid", {63'd0, ovalid0}, 64'd0);
    chk("flush_product_kept", p0, 64'd63);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ovalid0) seen = 1'b1;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);

    // Reset mid-calculation clears o_product.
    start_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'd0, 0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_product", p0, 64'd0);
    chk("rst_mid_ready", {63'd0, ready0}, 64'd1);
    chk("rst_mid_valid", {63'd0, ovalid0}, 64'd0);
    chk("rst_other_product", {32'd0, p2}, 64'd0);

    // Flush in DONE beats i_result_ready; product kept.
    start_op(0, 32'd3, 32'd5, 1'b0, 1'b0, 64'd15, 4, 1'b1);
    wait_result(0);
    rr    = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    rr    = 1'b0;
    flush = 1'b0;
    chk("flush_done_valid", {63'd0, ovalid0}, 64'd0);
    chk("flush_done_ready", {63'd0, ready0}, 64'd1);
    chk("flush_done_product", p0, 64'd15);

    // Flush in IDLE blocks the accept.
    @(negedge clk);
    valid0 = 1'b1;
    flush  = 1'b1;
    op_a   = 32'd2;
    op_b   = 32'd0;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    flush  = 1'b0;
    chk("flush_idle_ready", {63'd0, ready0}, 64'd1);
    chk("flush_idle_valid", {63'd0, ovalid0}, 64'd0);
    held = p0;
    chk("flush_idle_product", held, 64'd15);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
